cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//   Shares the single RAM port between the instruction cache and the data cache.
//   Sits between caches (icache/dcache miss/writeback traffic) and the RAM model.
//   Registered FSM grants one requester at a time and holds the grant until RAM reports ACCESS.
//   dcache has priority; a bounded streak counter guarantees icache forward progress.
// PARAMETERS
//   WORD_W       32  data/address width in bits
//   DSTREAK_MAX  4   consecutive dcache grants allowed while iREN pending before icache is forced
// PORTS
//   CLK       in   1       clock, rising edge
//   nRST      in   1       asynchronous active-low reset
//   iREN      in   1       icache read request
//   iaddr     in   WORD_W  icache address
//   iwait     out  1       0 = icache transfer completes this cycle
//   iload     out  WORD_W  read data to icache
//   dREN      in   1       dcache read request
//   dWEN      in   1       dcache write request
//   daddr     in   WORD_W  dcache address
//   dstore    in   WORD_W  dcache write data
//   dwait     out  1       0 = dcache transfer completes this cycle
//   dload     out  WORD_W  read data to dcache
//   ramREN    out  1       RAM read strobe
//   ramWEN    out  1       RAM write strobe
//   ramaddr   out  WORD_W  RAM address
//   ramstore  out  WORD_W  RAM write data
//   ramload   in   WORD_W  RAM read data
//   ramstate  in   2       FREE=0 BUSY=1 ACCESS=2 ERROR=3
// BEHAVIOUR
//   - Single clock CLK; reset nRST asynchronous, active-low.
//   - Reset: state=IDLE, streak=0; ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1.
//   - States: IDLE, IGRANT, DGRANT (registered). RAM outputs combinational from state + owner inputs.
//   - IDLE: RAM strobes 0, both waits 1. Next: DGRANT if (dREN|dWEN) && !(force_i);
//     else IGRANT if iREN; else IDLE. force_i = iREN && streak==DSTREAK_MAX.
//   - DGRANT: ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1,ramREN=0 (write wins over read);
//     else ramREN=dREN. dwait = (ramstate!=ACCESS); iwait=1.
//   - IGRANT: ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0. iwait=(ramstate!=ACCESS); dwait=1.
//   - Completion: ramstate==ACCESS in a grant state -> wait deasserted that cycle, next state IDLE.
//   - Latency: request seen in IDLE at cycle N, strobes at N+1, earliest wait=0 at N+1.
//     Minimum 2 cycles request-to-completion; one IDLE bubble between back-to-back transfers.
//   - Withdrawal: owner drops all its requests before ACCESS -> strobes 0 that cycle, IDLE next.
//   - ramstate BUSY/FREE/ERROR in grant state: hold grant and outputs, wait stays 1.
//   - iload = dload = ramload at all times (consumers qualify with their wait).
//   - streak: on completion of a DGRANT with iREN=1, streak+=1 (saturate at DSTREAK_MAX);
//     on entering IGRANT or when iREN=0 in IDLE, streak=0.
//   - Simultaneous iREN and dREN in IDLE with streak<DSTREAK_MAX -> DGRANT.
//   - Reset asserted mid-transfer: strobes drop immediately (async), state IDLE, no completion pulse.
// CONFIGURATION
//   ARB_STATS_EN defined: extra outputs icount, dcount (32-bit each), reset to 0,
//     increment by 1 on each completed IGRANT/DGRANT transfer, wrap 0xFFFFFFFF->0.
//   ARB_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//   1 Reset: nRST=0 -> ramREN=ramWEN=0, iwait=dwait=1, state IDLE; held with iREN=1 no grant.
//   2 icache read: iREN=1 iaddr=0x100, RAM ACCESS 1 cycle after strobe, ramload=0xDEADBEEF
//     -> ramaddr=0x100 ramREN=1 at N+1, iwait=0 iload=0xDEADBEEF at completion cycle.
//   3 Conflict: iREN=1 and dWEN=1 daddr=0x200 dstore=0x1234 together -> dcache served first
//     (ramWEN=1 ramstore=0x1234), icache granted after one IDLE cycle.
//   4 Starvation: iREN=1 held, dREN=1 held, DSTREAK_MAX=4 -> exactly 4 dcache completions, then IGRANT.
//   5 Withdrawal/ERROR: dcache drops dREN while ramstate=BUSY -> strobes 0, IDLE next;
//     ramstate=ERROR 10 cycles -> grant held, dwait=1 throughout.
//   6 ARB_STATS_EN: 3 icache + 5 dcache transfers -> icount=3, dcount=5; async reset mid-transfer -> both 0.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache-side and RAM-side signal bundle for cache_mem_arbiter
interface cache_mem_arbiter_if #(
    parameter int WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    // slave: the arbiter's view; master: the caches plus RAM driving it
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache arbiter for one RAM port; ARB_STATS_EN adds transfer counters
module cache_mem_arbiter #(
    parameter int WORD_W      = 32,
    parameter int DSTREAK_MAX = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    cache_mem_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]         icount,
    output logic [31:0]         dcount
`endif
);
    localparam int         SW         = $clog2(DSTREAK_MAX + 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_next;

    logic d_req;
    logic force_i;
    logic access;

    assign d_req   = bus.dREN | bus.dWEN;
    assign force_i = bus.iREN && (streak == SW'(DSTREAK_MAX));
    assign access  = (bus.ramstate == RAM_ACCESS);

    // Data is passed straight through; each cache qualifies it with its own wait.
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    always_comb begin
        state_next   = state;
        streak_next  = streak;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;

        case (state)
            IDLE: begin
                if (!bus.iREN) begin
                    streak_next = '0;
                end
                if (d_req && !force_i) begin
                    state_next = DGRANT;
                end else if (bus.iREN) begin
                    state_next  = IGRANT;
                    streak_next = '0;
                end
            end

            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (bus.dWEN) begin
                    bus.ramWEN = 1'b1;
                end else begin
                    bus.ramREN = bus.dREN;
                end
                bus.dwait = !access;
                // Each dcache win while icache waits brings the forced icache grant closer.
                if (access) begin
                    state_next = IDLE;
                    if (bus.iREN && (streak != SW'(DSTREAK_MAX))) begin
                        streak_next = streak + SW'(1);
                    end
                end else if (!d_req) begin
                    state_next = IDLE;
                end
            end

            IGRANT: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                bus.iwait   = !access;
                if (access || !bus.iREN) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount <= '0;
            dcount <= '0;
        end else begin
            if ((state == IGRANT) && access) begin
                icount <= icount + 32'd1;
            end
            if ((state == DGRANT) && access) begin
                dcount <= dcount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter with a one-cycle RAM model
module tb_cache_mem_arbiter;
    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic CLK;
    logic nRST;
    int   checks;
    int   errors;
    int   cyc;
    int   ram_mode;
    xfer_t sb[$];
    int    done_cyc[$];

`ifdef ARB_STATS_EN
    logic [31:0] icount;
    logic [31:0] dcount;
`endif

    cache_mem_arbiter_if #(.WORD_W(32)) bus();

    cache_mem_arbiter #(
        .WORD_W      (32),
        .DSTREAK_MAX (4)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .bus    (bus.slave)
`ifdef ARB_STATS_EN
        ,
        .icount (icount),
        .dcount (dcount)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return (a ^ 32'hC0DE_0000) + 32'h11;
    endfunction

    assign bus.ramload = mem_val(bus.ramaddr);

    // RAM answers ACCESS in the cycle after it first sees a strobe.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bus.ramstate <= RS_FREE;
        end else if (ram_mode == 1) begin
            bus.ramstate <= RS_BUSY;
        end else if (ram_mode == 2) begin
            bus.ramstate <= RS_ERROR;
        end else if ((bus.ramREN || bus.ramWEN) && (bus.ramstate != RS_ACCESS)) begin
            bus.ramstate <= RS_ACCESS;
        end else begin
            bus.ramstate <= RS_FREE;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        xfer_t e;
        e.is_d = is_d;
        e.wr   = wr;
        e.addr = addr;
        e.data = wr ? data : mem_val(addr);
        sb.push_back(e);
    endtask

    // Collect n completions within budget cycles, comparing each to the scoreboard head.
    task automatic serve(input int n, input bit drop, input int budget);
        int    got;
        int    spent;
        xfer_t e;
        got   = 0;
        spent = 0;
        while (got < n && spent < budget) begin
            @(negedge CLK);
            spent++;
            if (!bus.iwait || !bus.dwait) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("owner_iwait", 32'(bus.iwait), e.is_d ? 32'd1 : 32'd0);
                    chk("owner_dwait", 32'(bus.dwait), e.is_d ? 32'd0 : 32'd1);
                    chk("done_addr", bus.ramaddr, e.addr);
                    chk("done_wen", 32'(bus.ramWEN), 32'(e.wr));
                    chk("done_ren", 32'(bus.ramREN), 32'(!e.wr));
                    if (e.wr) chk("done_store", bus.ramstore, e.data);
                    else if (e.is_d) chk("done_dload", bus.dload, e.data);
                    else chk("done_iload", bus.iload, e.data);
                    done_cyc.push_back(cyc);
                    if (drop) begin
                        if (e.is_d) begin
                            bus.dREN = 1'b0;
                            bus.dWEN = 1'b0;
                        end else begin
                            bus.iREN = 1'b0;
                        end
                    end
                end
                got++;
            end
        end
        chk("serve_count", 32'(got), 32'(n));
    endtask

    initial begin
        int t0;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        ram_mode = 0;
        nRST     = 1'b0;
        bus.iREN = 1'b1;
        bus.iaddr = 32'h100;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        bus.daddr = '0;
        bus.dstore = '0;

        // 1: reset holds everything idle even with a pending icache request
        repeat (3) begin
            @(negedge CLK);
            chk("rst_ramren", 32'(bus.ramREN), 32'd0);
            chk("rst_iwait", 32'(bus.iwait), 32'd1);
        end
        chk("rst_ramwen", 32'(bus.ramWEN), 32'd0);
        chk("rst_dwait", 32'(bus.dwait), 32'd1);
        chk("rst_ramaddr", bus.ramaddr, 32'd0);
        chk("rst_ramstore", bus.ramstore, 32'd0);
        bus.iREN = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);
        chk("idle_ramren", 32'(bus.ramREN), 32'd0);

        // 2: single icache read
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h100;
        t0 = cyc;
        push(1'b0, 1'b0, 32'h100, '0);
        @(negedge CLK);
        chk("ird_strobe", 32'(bus.ramREN), 32'd1);
        chk("ird_addr", bus.ramaddr, 32'h100);
        chk("ird_wait_pre", 32'(bus.iwait), 32'd1);
        serve(1, 1'b1, 10);
        chk("ird_latency", 32'(done_cyc[done_cyc.size()-1] - t0), 32'd2);

        // 3: simultaneous requests, dcache write first, one idle bubble, then icache
        @(negedge CLK);
        bus.iREN   = 1'b1;
        bus.iaddr  = 32'h500;
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h200;
        bus.dstore = 32'h1234;
        push(1'b1, 1'b1, 32'h200, 32'h1234);
        push(1'b0, 1'b0, 32'h500, '0);
        serve(2, 1'b1, 20);
        chk("conflict_gap", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'd3);

        // 4: dcache keeps winning until the streak forces an icache grant
        @(negedge CLK);
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h300;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h400;
        repeat (4) push(1'b1, 1'b0, 32'h400, '0);
        push(1'b0, 1'b0, 32'h300, '0);
        serve(5, 1'b0, 40);
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        @(negedge CLK);

        // 5a: withdrawal while RAM is busy
        ram_mode  = 1;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h600;
        @(negedge CLK);
        chk("wd_strobe", 32'(bus.ramREN), 32'd1);
        chk("wd_addr", bus.ramaddr, 32'h600);
        chk("wd_dwait", 32'(bus.dwait), 32'd1);
        bus.dREN = 1'b0;
        #1;
        chk("wd_strobe_drop", 32'(bus.ramREN), 32'd0);
        @(negedge CLK);
        chk("wd_idle_addr", bus.ramaddr, 32'd0);
        chk("wd_idle_dwait", 32'(bus.dwait), 32'd1);

        // 5b: ERROR holds the grant with dwait high
        ram_mode  = 2;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h700;
        @(negedge CLK);
        repeat (10) begin
            @(negedge CLK);
            chk("err_dwait", 32'(bus.dwait), 32'd1);
            chk("err_strobe", 32'(bus.ramREN), 32'd1);
        end
        chk("err_addr", bus.ramaddr, 32'h700);
        ram_mode = 0;
        push(1'b1, 1'b0, 32'h700, '0);
        serve(1, 1'b1, 10);

        // 6: counters, then asynchronous reset in the middle of a transfer
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            bus.iREN  = 1'b1;
            bus.iaddr = 32'h800 + 32'(k * 4);
            push(1'b0, 1'b0, bus.iaddr, '0);
            serve(1, 1'b1, 10);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            bus.dREN  = 1'b1;
            bus.daddr = 32'h900 + 32'(k * 4);
            push(1'b1, 1'b0, bus.daddr, '0);
            serve(1, 1'b1, 10);
        end
`ifdef ARB_STATS_EN
        @(negedge CLK);
        chk("stats_icount", icount, 32'd3);
        chk("stats_dcount", dcount, 32'd5);
`endif
        @(negedge CLK);
        bus.dREN  = 1'b1;
        bus.daddr = 32'hA00;
        @(negedge CLK);
        chk("mid_strobe", 32'(bus.ramREN), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_strobe", 32'(bus.ramREN), 32'd0);
        chk("arst_dwait", 32'(bus.dwait), 32'd1);
        chk("arst_addr", bus.ramaddr, 32'd0);
`ifdef ARB_STATS_EN
        chk("arst_icount", icount, 32'd0);
        chk("arst_dcount", dcount, 32'd0);
`endif
        @(negedge CLK);
        bus.dREN = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);
        chk("post_rst_dwait", 32'(bus.dwait), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
